// File: rtl/ntt_bitrev_loader.sv
// Loads one RING_SIZE-coefficient frame and writes it across NUM_BANKS coefficient RAM banks in bit-reversed or natural order.
// One cycle from an accepted beat to its bank write. in_ready_o is high only in LOAD, and done_o pulses with the last write.
module ntt_bitrev_loader #(
  parameter int DATA_W    = 32,
  parameter int RING_SIZE = 256,
  parameter int NUM_BANKS = 2,
  localparam int LOG_N    = $clog2(RING_SIZE),
  localparam int LOG_B    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
  localparam int AW       = LOG_N - LOG_B
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 start_i,
  input  logic                 mode_bitrev_i,
  input  logic                 in_valid_i,
  input  logic [DATA_W-1:0]    in_data_i,
  output logic                 in_ready_o,
  output logic [NUM_BANKS-1:0] wr_en_o,
  output logic [AW-1:0]        wr_addr_o,
  output logic [DATA_W-1:0]    wr_data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state_q, state_d;
  logic [LOG_N-1:0]      count_q, count_d;
  logic                  mode_q, mode_d;
  logic [NUM_BANKS-1:0]  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;

  logic [LOG_N-1:0]      count_rev;
  logic [LOG_N-1:0]      idx;
  logic [LOG_N-1:0]      bank_sel;
  logic [NUM_BANKS-1:0]  bank_onehot;

  always_comb begin
    count_rev = '0;
    for (int i = 0; i < LOG_N; i++) begin
      count_rev[i] = count_q[LOG_N-1-i];
    end
  end

  // Bank comes from the top LOG_B index bits; with one bank the shift clears it to zero.
  assign idx         = mode_q ? count_rev : count_q;
  assign bank_sel    = idx >> AW;
  assign bank_onehot = NUM_BANKS'(1) << bank_sel;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mode_d    = mode_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          count_d = '0;
          mode_d  = mode_bitrev_i;
        end
      end
      LOAD: begin
        if (in_valid_i) begin
          wr_en_d   = bank_onehot;
          wr_addr_d = idx[AW-1:0];
          wr_data_d = in_data_i;
          if (count_q == LOG_N'(RING_SIZE - 1)) begin
            state_d = DONE;
          end else begin
            count_d = count_q + LOG_N'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mode_q    <= 1'b1;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready_o = (state_q == LOAD);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_ntt_bitrev_loader.sv
// Runs three loader configurations (8x2, 16x4, 8x1) that share their inputs but have separate starts.
// Every output is compared each cycle against a frame-level reference model.
module tb_ntt_bitrev_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start;
  logic        mode, vld;
  logic [15:0] dat;

  logic [1:0]  en0, ad0;
  logic [3:0]  en1;
  logic [1:0]  ad1;
  logic [0:0]  en2;
  logic [2:0]  ad2;
  logic [15:0] wd0, wd1, wd2;
  logic        rdy0, rdy1, rdy2, bz0, bz1, bz2, dn0, dn1, dn2;

  ntt_bitrev_loader #(.DATA_W(16), .RING_SIZE(8), .NUM_BANKS(2)) u0 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start[0]), .mode_bitrev_i(mode),
    .in_valid_i(vld), .in_data_i(dat), .in_ready_o(rdy0), .wr_en_o(en0),
    .wr_addr_o(ad0), .wr_data_o(wd0), .busy_o(bz0), .done_o(dn0));
  ntt_bitrev_loader #(.DATA_W(16), .RING_SIZE(16), .NUM_BANKS(4)) u1 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start[1]), .mode_bitrev_i(mode),
    .in_valid_i(vld), .in_data_i(dat), .in_ready_o(rdy1), .wr_en_o(en1),
    .wr_addr_o(ad1), .wr_data_o(wd1), .busy_o(bz1), .done_o(dn1));
  ntt_bitrev_loader #(.DATA_W(16), .RING_SIZE(8), .NUM_BANKS(1)) u2 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start[2]), .mode_bitrev_i(mode),
    .in_valid_i(vld), .in_data_i(dat), .in_ready_o(rdy2), .wr_en_o(en2),
    .wr_addr_o(ad2), .wr_data_o(wd2), .busy_o(bz2), .done_o(dn2));

  logic [3:0]  o_en[3], o_addr[3];
  logic [15:0] o_dat[3];
  logic        o_rdy[3], o_busy[3], o_done[3];
  assign o_en[0] = {2'b0, en0};  assign o_addr[0] = {2'b0, ad0};
  assign o_en[1] = en1;          assign o_addr[1] = {2'b0, ad1};
  assign o_en[2] = {3'b0, en2};  assign o_addr[2] = {1'b0, ad2};
  assign o_dat[0] = wd0;  assign o_dat[1] = wd1;  assign o_dat[2] = wd2;
  assign o_rdy[0] = rdy0; assign o_rdy[1] = rdy1; assign o_rdy[2] = rdy2;
  assign o_busy[0] = bz0; assign o_busy[1] = bz1; assign o_busy[2] = bz2;
  assign o_done[0] = dn0; assign o_done[1] = dn1; assign o_done[2] = dn2;

  // Reference model: frame phase (0 idle, 1 loading, 2 done), beat number and latched order per instance.
  int NN[3] = '{8, 16, 8};
  int BB[3] = '{2, 4, 1};
  int LN[3] = '{3, 4, 3};
  int ph[3] = '{0, 0, 0};
  int cnt[3] = '{0, 0, 0};
  bit md[3] = '{1, 1, 1};
  logic [3:0]  e_en[3], e_addr[3];
  logic [15:0] e_dat[3];

  logic [3:0] log_en[3][64];
  logic [3:0] log_addr[3][64];
  logic       log_done[3][64];
  int nlog[3], done_cnt[3];
  int tests = 0, fails = 0, cyc_no = 0;

  function automatic int rev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 3; k++) begin nlog[k] = 0; done_cnt[k] = 0; end
  endtask

  task automatic cyc(input logic [2:0] s, input logic v);
    logic [15:0] d;
    int idx, per;
    d = 16'($urandom);
    start = s; vld = v; dat = d;
    for (int k = 0; k < 3; k++)
      chk($sformatf("u%0d.in_ready", k), 32'(o_rdy[k]), 32'(ph[k] == 1));
    @(posedge clk); #1;
    cyc_no++;
    for (int k = 0; k < 3; k++) begin
      e_en[k] = '0;
      if (!rst_n) begin
        ph[k] = 0; cnt[k] = 0; md[k] = 1'b1; e_addr[k] = '0; e_dat[k] = '0;
      end else begin
        case (ph[k])
          0: if (s[k]) begin ph[k] = 1; cnt[k] = 0; md[k] = mode; end
          1: if (v) begin
               per = NN[k] / BB[k];
               idx = md[k] ? rev(cnt[k], LN[k]) : cnt[k];
               e_en[k] = 4'(1 << (idx / per));
               e_addr[k] = 4'(idx % per);
               e_dat[k] = d;
               if (cnt[k] == NN[k] - 1) ph[k] = 2; else cnt[k]++;
             end
          default: ph[k] = 0;
        endcase
      end
      chk($sformatf("u%0d.wr_en", k), 32'(o_en[k]), 32'(e_en[k]));
      chk($sformatf("u%0d.wr_addr", k), 32'(o_addr[k]), 32'(e_addr[k]));
      chk($sformatf("u%0d.wr_data", k), 32'(o_dat[k]), 32'(e_dat[k]));
      chk($sformatf("u%0d.done", k), 32'(o_done[k]), 32'(ph[k] == 2));
      chk($sformatf("u%0d.busy", k), 32'(o_busy[k]), 32'(ph[k] != 0));
      if (o_en[k] != 0 && nlog[k] < 64) begin
        log_en[k][nlog[k]] = o_en[k];
        log_addr[k][nlog[k]] = o_addr[k];
        log_done[k][nlog[k]] = o_done[k];
        nlog[k]++;
      end
      if (o_done[k] === 1'b1) done_cnt[k]++;
    end
  endtask

  task automatic frame(input int k, input logic m, input int pct, input bit noisy);
    bit got;
    logic [2:0] ss;
    mode = m;
    cyc(3'(1 << k), 1'b0);
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      ss = noisy ? 3'($urandom_range(1) << k) : 3'b000;
      if (noisy) mode = 1'($urandom);
      cyc(ss, 1'($urandom_range(99) < pct));
      got = o_done[k];
    end
    chk($sformatf("u%0d.frame_done_in_budget", k), 32'(got), 32'd1);
    cyc(3'b000, 1'b0);
  endtask

  initial begin
    int ea[8], ee[8];
    int tdone;
    bit got, prv;
    rst_n = 1'b0; start = '0; mode = 1'b0; vld = 1'b0; dat = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc(3'b000, 1'b1);
    rst_n = 1'b1;
    cyc(3'b000, 1'b0);

    // 8x2 bit-reversed, back-to-back beats
    clear_logs();
    frame(0, 1'b1, 100, 0);
    ea = '{0, 0, 2, 2, 1, 1, 3, 3};
    ee = '{1, 2, 1, 2, 1, 2, 1, 2};
    chk("t1.writes", 32'(nlog[0]), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1.addr%0d", i), 32'(log_addr[0][i]), 32'(ea[i]));
      chk($sformatf("t1.en%0d", i), 32'(log_en[0][i]), 32'(ee[i]));
    end
    chk("t1.done_with_last_write", 32'(log_done[0][7]), 32'd1);
    chk("t1.done_count", 32'(done_cnt[0]), 32'd1);

    // 8x2 natural order
    clear_logs();
    frame(0, 1'b0, 100, 0);
    ea = '{0, 1, 2, 3, 0, 1, 2, 3};
    ee = '{1, 1, 1, 1, 2, 2, 2, 2};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2.addr%0d", i), 32'(log_addr[0][i]), 32'(ea[i]));
      chk($sformatf("t2.en%0d", i), 32'(log_en[0][i]), 32'(ee[i]));
    end

    // 16x4 with in_valid toggling every other cycle
    clear_logs();
    mode = 1'b1;
    cyc(3'b010, 1'b0);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      cyc(3'b000, 1'(i % 2 == 0));
      got = o_done[1];
    end
    chk("t3.done_in_budget", 32'(got), 32'd1);
    cyc(3'b000, 1'b0);
    chk("t3.writes", 32'(nlog[1]), 32'd16);
    chk("t3.c1_bank", 32'(log_en[1][1]), 32'd4);
    chk("t3.c1_addr", 32'(log_addr[1][1]), 32'd0);
    chk("t3.c3_bank", 32'(log_en[1][3]), 32'd8);
    chk("t3.c3_addr", 32'(log_addr[1][3]), 32'd0);

    // reset after 5 beats abandons the frame
    clear_logs();
    mode = 1'b1;
    cyc(3'b001, 1'b0);
    repeat (5) cyc(3'b000, 1'b1);
    rst_n = 1'b0;
    cyc(3'b000, 1'b1);
    rst_n = 1'b1;
    frame(0, 1'b1, 100, 0);
    chk("t4.writes", 32'(nlog[0]), 32'd13);
    chk("t4.restart_bank", 32'(log_en[0][5]), 32'd1);
    chk("t4.restart_addr", 32'(log_addr[0][5]), 32'd0);
    chk("t4.done_count", 32'(done_cnt[0]), 32'd1);

    // start held across three frames
    clear_logs();
    mode = 1'b1;
    tdone = -1;
    prv = 0;
    for (int i = 0; i < 100 && done_cnt[0] < 3; i++) begin
      cyc(3'b001, 1'b1);
      if (o_done[0]) tdone = cyc_no;
      if (o_rdy[0] && !prv && tdone >= 0)
        chk("t5.restart_gap", 32'(cyc_no - tdone), 32'd2);
      prv = o_rdy[0];
    end
    cyc(3'b000, 1'b0);
    cyc(3'b000, 1'b0);
    chk("t5.frames", 32'(done_cnt[0]), 32'd3);
    chk("t5.writes", 32'(nlog[0]), 32'd24);

    // single bank, bit-reversed, random bubbles
    clear_logs();
    frame(2, 1'b1, 50, 0);
    ea = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6.addr%0d", i), 32'(log_addr[2][i]), 32'(ea[i]));
      chk($sformatf("t6.en%0d", i), 32'(log_en[2][i]), 32'd1);
    end

    // random frames with bubbles, stray starts and mode changes mid-frame
    for (int r = 0; r < 6; r++) frame(r % 3, 1'($urandom), 60, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ntt_bitrev_loader.md
Name: ntt_bitrev_loader

Overview:
- Parametrised successor of the NTT input bit-reverse stage.
- Accepts one polynomial frame of RING_SIZE coefficients over a valid/ready stream.
- Scatters each coefficient into one of NUM_BANKS coefficient RAM banks at its bit-reversed (or natural-order) position.
- Signals frame completion to the NTT controller with a single-cycle done pulse.
- Sits between the input interface and the banked coefficient memories feeding the butterfly datapath.

Parameters:
- DATA_W, 32, coefficient width in bits.
- RING_SIZE, 256, coefficients per frame; power of 2, at least 4.
- NUM_BANKS, 2, number of coefficient RAM banks; power of 2, 1 <= NUM_BANKS <= RING_SIZE/2.
- Derived LOG_N = $clog2(RING_SIZE).
- Derived LOG_B = $clog2(NUM_BANKS), 0 when NUM_BANKS = 1.
- Derived AW = LOG_N - LOG_B, the per-bank address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begins a frame; sampled only in IDLE.
- mode_bitrev  in  1  1 = bit-reversed placement, 0 = natural order; latched on an accepted start.
- in_valid  in  1  input coefficient valid.
- in_data  in  DATA_W  input coefficient.
- in_ready  out  1  loader can accept a coefficient.
- wr_en  out  NUM_BANKS  one-hot bank write enable.
- wr_addr  out  AW  address within the selected bank.
- wr_data  out  DATA_W  coefficient to write.
- busy  out  1  high while in LOAD or DONE.
- done  out  1  one-cycle pulse when the last write of a frame is issued.

Behaviour:
- States: IDLE, LOAD, DONE.
  - IDLE: start=1 -> LOAD; latch mode_bitrev; clear count.
  - LOAD: in_ready=1; a beat is accepted when in_valid && in_ready; count increments per beat. The beat where count = RING_SIZE-1 -> DONE.
  - DONE: lasts exactly one cycle; in_ready=0; -> IDLE.
- in_ready is 0 in IDLE and DONE; it is driven combinationally from state only.
- count is LOG_N bits, 0..RING_SIZE-1. Termination is decided on count = RING_SIZE-1 with an accepted beat, never on count reaching RING_SIZE.
- Placement of beat with count c:
  - idx = bitreverse_LOG_N(c) when mode latched = 1, else idx = c.
  - bank = idx[LOG_N-1 -: LOG_B]; wr_addr = idx[AW-1:0].
  - NUM_BANKS = 1: bank is always 0 and wr_addr = idx.
- Output timing:
  - wr_en, wr_addr and wr_data are registered with 1-cycle latency after the accepting edge.
  - wr_en = one-hot(bank) for exactly one cycle per accepted beat; otherwise all zeros.
  - wr_addr and wr_data hold their last values when wr_en = 0.
- done is asserted in the cycle the final wr_en is asserted, which is the DONE state cycle. busy = (state != IDLE).
- Cycles without in_valid in LOAD insert bubbles: no write, count holds. There is no timeout.
- start is ignored outside IDLE. A mode_bitrev change mid-frame has no effect.
- Back-to-back frames: start may be asserted in the IDLE cycle right after DONE, giving at most 2 dead cycles between frames.
- Reset (reset=0 at a clk edge), effective from any state including mid-frame:
  - state = IDLE, count = 0, latched mode = 1.
  - wr_en = 0, wr_addr = 0, wr_data = 0, done = 0, busy = 0.
  - A partial frame is abandoned; no done is produced for it.

Test Plan:
- N=8, B=2, W=16, mode=1, 8 consecutive beats with data 0..7 -> wr_en = 01,10,01,10,01,10,01,10; wr_addr = 0,0,2,2,1,1,3,3; done high in the same cycle as the 8th wr_en; in_ready low that cycle.
- Same configuration, mode=0 -> bank = 0,0,0,0,1,1,1,1; wr_addr = 0,1,2,3,0,1,2,3.
- N=16, B=4, mode=1, in_valid toggling every other cycle -> 16 writes total; beat c=1 goes to bank 2, addr 0; beat c=3 goes to bank 3, addr 0; no write in gap cycles; done after the 16th beat.
- Reset pulled low after 5 beats, then a new start with 8 beats -> no done for the aborted frame; the new frame starts at c=0 (bank 0, addr 0); exactly one done.
- start held high continuously over 3 frames -> frames begin 2 cycles after each done; start pulses during LOAD do not restart the count.
- N=8, B=1 -> wr_en always 1-bit high; wr_addr = 0,4,2,6,1,5,3,7.
